// File: rtl/divvy_pkg.sv
// Shared types and defaults for the Divvy program-counter sequencer.
// Holds the sequencer state encoding and the width/start-address defaults.
package divvy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LOOKUP = 2'd2,
        HALT   = 2'd3
    } pc_state_t;

    localparam int PC_W_DEF     = 16;
    localparam int IDX_W_DEF    = 8;
    localparam int START_PC_DEF = 0;

    // The table may only be rewritten while the core is not fetching.
    function automatic logic is_cfg_state(input pc_state_t s);
        return (s == IDLE) || (s == HALT);
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch-target table: 2**IDX_W entries of PC_W bits, one write port, registered read.
// All entries clear to zero on reset.
module branch_lut #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [PC_W-1:0]  wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [PC_W-1:0]  rd_data
);

    localparam int DEPTH = 1 << IDX_W;

    logic [PC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Divvy program-counter sequencer: sequential fetch, table-driven taken branches, halt/restart.
// Optional PC_BRANCH_CNT_EN adds a saturating 16-bit Branch_cnt of lookups.
module pc_branch_ctrl
    import divvy_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              IDX_W    = IDX_W_DEF,
    parameter logic [PC_W-1:0] START_PC = PC_W'(START_PC_DEF)
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Stall,
    input  logic             Halt_req,
    input  logic             Branch_req,
    input  logic             Cond,
    input  logic [IDX_W-1:0] Branch_idx,
    input  logic             Cfg_we,
    input  logic [IDX_W-1:0] Cfg_addr,
    input  logic [PC_W-1:0]  Cfg_data,
    output logic             Cfg_ready,
    output logic [PC_W-1:0]  PC,
    output logic             PC_valid,
    output logic             Done
`ifdef PC_BRANCH_CNT_EN
   ,output logic [15:0]      Branch_cnt
`endif
);

    pc_state_t       state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            valid_nxt;
    logic            lut_rd_en;
    logic            lut_we;
    logic [PC_W-1:0] lut_data;

    assign lut_we = Cfg_we && is_cfg_state(state);

    branch_lut #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) u_lut (
        .clk     (CLK),
        .rst_n   (Reset_n),
        .we      (lut_we),
        .wr_addr (Cfg_addr),
        .wr_data (Cfg_data),
        .rd_en   (lut_rd_en),
        .rd_addr (Branch_idx),
        .rd_data (lut_data)
    );

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        valid_nxt = PC_valid;
        lut_rd_en = 1'b0;
        case (state)
            IDLE, HALT: begin
                valid_nxt = 1'b0;
                if (state == IDLE) begin
                    pc_nxt = START_PC;
                end
                if (Start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                    valid_nxt = 1'b1;
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (Halt_req) begin
                        state_nxt = HALT;
                        valid_nxt = 1'b0;
                    end else if (Branch_req && Cond) begin
                        state_nxt = LOOKUP;
                        valid_nxt = 1'b0;
                        lut_rd_en = 1'b1;
                    end else begin
                        pc_nxt    = PC + PC_W'(1);
                        valid_nxt = 1'b1;
                    end
                end
            end
            LOOKUP: begin
                // The table read issued on entry is now available.
                state_nxt = RUN;
                pc_nxt    = lut_data;
                valid_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = START_PC;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            PC        <= START_PC;
            PC_valid  <= 1'b0;
            Done      <= 1'b0;
            Cfg_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            PC        <= pc_nxt;
            PC_valid  <= valid_nxt;
            Done      <= (state_nxt == HALT);
            Cfg_ready <= is_cfg_state(state_nxt);
        end
    end

`ifdef PC_BRANCH_CNT_EN
    logic [15:0] branch_cnt_q;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            branch_cnt_q <= '0;
        end else if (is_cfg_state(state) && Start) begin
            branch_cnt_q <= '0;
        end else if (lut_rd_en && (branch_cnt_q != 16'hFFFF)) begin
            branch_cnt_q <= branch_cnt_q + 16'd1;
        end
    end

    assign Branch_cnt = branch_cnt_q;
`endif

endmodule
